rrf_tag_alloc_ctrl: RTL and testbench

- Allocation and retire controller for the rename register file (RRF) used by the register file's destination mapping.
- Hands out RRF tags in program order to two decode slots (A older than B) as a circular buffer, and frees tags in order at retire.
- Reports full and error conditions that feed the register file's rename-error path and the decode stall logic.

---
 rtl/rrf_tag_alloc_ctrl.sv | 92 +++++++++
 tb/tb_rrf_tag_alloc_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rrf_tag_alloc_ctrl.sv
// Rename register file tag allocator: in-order circular allocation to two decode
// slots, in-order retire, flush back to the retire point, occupancy reporting.
module rrf_tag_alloc_ctrl #(
  parameter int RRF_DEPTH = 32,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req_A,
  input  logic             alloc_req_B,
  output logic             alloc_gnt_A,
  output logic             alloc_gnt_B,
  output logic [TAG_W-1:0] alloc_tag_A,
  output logic [TAG_W-1:0] alloc_tag_B,
  output logic             wrA_rrError,
  output logic             wrB_rrError,
  input  logic             ret_en_A,
  input  logic             ret_en_B,
  output logic [TAG_W-1:0] ret_tag_A,
  output logic [TAG_W-1:0] ret_tag_B,
  output logic             ret_err,
  input  logic             flush,
  output logic [TAG_W:0]   free_cnt,
  output logic             full,
  output logic             empty
);

  localparam logic [TAG_W:0] DEPTH_V = (TAG_W+1)'(RRF_DEPTH);

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   occ_q, occ_d;

  logic [TAG_W:0] free_now;
  logic [TAG_W:0] n_req_ret;
  logic [TAG_W:0] n_ret;
  logic [TAG_W:0] n_gnt;
  logic           raw_gnt_A;
  logic           raw_gnt_B;
  logic           quiet;

  always_comb begin
    free_now  = DEPTH_V - occ_q;
    quiet     = rst | flush;

    raw_gnt_A = alloc_req_A & (free_now >= (TAG_W+1)'(1));
    raw_gnt_B = alloc_req_B & (alloc_req_A ? (free_now >= (TAG_W+1)'(2))
                                           : (free_now >= (TAG_W+1)'(1)));

    alloc_gnt_A = raw_gnt_A & ~quiet;
    alloc_gnt_B = raw_gnt_B & ~quiet;
    wrA_rrError = alloc_req_A & ~raw_gnt_A & ~quiet;
    wrB_rrError = alloc_req_B & ~raw_gnt_B & ~quiet;

    // B shares the tail slot when A is idle
    alloc_tag_A = tail_q;
    alloc_tag_B = tail_q + TAG_W'(alloc_req_A);

    n_req_ret = (TAG_W+1)'(ret_en_A) + (TAG_W+1)'(ret_en_B);
    n_ret     = (n_req_ret > occ_q) ? occ_q : n_req_ret;
    ret_err   = (n_req_ret > occ_q) & ~quiet;
    ret_tag_A = head_q;
    ret_tag_B = head_q + TAG_W'(ret_en_A);

    n_gnt  = (TAG_W+1)'(alloc_gnt_A) + (TAG_W+1)'(alloc_gnt_B);
    head_d = head_q + n_ret[TAG_W-1:0];
    if (flush) begin
      tail_d = head_d;
      occ_d  = '0;
    end else begin
      tail_d = tail_q + n_gnt[TAG_W-1:0];
      occ_d  = occ_q + n_gnt - n_ret;
    end

    free_cnt = free_now;
    full     = (occ_q == DEPTH_V);
    empty    = (occ_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: tb/tb_rrf_tag_alloc_ctrl.sv
// Directed bench for rrf_tag_alloc_ctrl at depth 8; expectations are queued as
// stimulus is applied and popped when the corresponding output is observed.
module tb_rrf_tag_alloc_ctrl;

  localparam int DEPTH = 8;
  localparam int TW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req_A, alloc_req_B;
  logic          alloc_gnt_A, alloc_gnt_B;
  logic [TW-1:0] alloc_tag_A, alloc_tag_B;
  logic          wrA_rrError, wrB_rrError;
  logic          ret_en_A, ret_en_B;
  logic [TW-1:0] ret_tag_A, ret_tag_B;
  logic          ret_err;
  logic          flush;
  logic [TW:0]   free_cnt;
  logic          full, empty;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  rrf_tag_alloc_ctrl #(.RRF_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .alloc_req_A(alloc_req_A), .alloc_req_B(alloc_req_B),
    .alloc_gnt_A(alloc_gnt_A), .alloc_gnt_B(alloc_gnt_B),
    .alloc_tag_A(alloc_tag_A), .alloc_tag_B(alloc_tag_B),
    .wrA_rrError(wrA_rrError), .wrB_rrError(wrB_rrError),
    .ret_en_A(ret_en_A), .ret_en_B(ret_en_B),
    .ret_tag_A(ret_tag_A), .ret_tag_B(ret_tag_B),
    .ret_err(ret_err), .flush(flush),
    .free_cnt(free_cnt), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic expect_v(input int v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input int obs);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%0d expected=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  // inputs change 1 time unit after the rising edge; outputs sampled 2 units later
  task automatic drive(input logic ra, input logic rb, input logic ta,
                       input logic tb, input logic fl);
    alloc_req_A = ra; alloc_req_B = rb;
    ret_en_A = ta; ret_en_B = tb; flush = fl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_v(0); chk("rst_gnt_A", alloc_gnt_A);
    expect_v(0); chk("rst_gnt_B", alloc_gnt_B);
    expect_v(0); chk("rst_wrA_err", wrA_rrError);
    expect_v(0); chk("rst_ret_err", ret_err);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_v(8); chk("rst_free_cnt", free_cnt);
    expect_v(1); chk("rst_empty", empty);
    expect_v(0); chk("rst_full", full);

    // 1: fill with slot A only
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_v(1); chk("t1_gnt_A", alloc_gnt_A);
      expect_v(i); chk("t1_tag_A", alloc_tag_A);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_v(1); chk("t1_full", full);
    expect_v(0); chk("t1_free_cnt", free_cnt);
    expect_v(0); chk("t1_9th_gnt_A", alloc_gnt_A);
    expect_v(1); chk("t1_9th_wrA_err", wrA_rrError);

    // 2: dual allocation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_v(1);     chk("t2_gnt_A", alloc_gnt_A);
      expect_v(1);     chk("t2_gnt_B", alloc_gnt_B);
      expect_v(2*i);   chk("t2_tag_A", alloc_tag_A);
      expect_v(2*i+1); chk("t2_tag_B", alloc_tag_B);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_v(6-2*i); chk("t2_free_cnt", free_cnt);
    end

    // 3: one free entry, both slots request
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_v(1); chk("t3_gnt_A", alloc_gnt_A);
    expect_v(7); chk("t3_tag_A", alloc_tag_A);
    expect_v(0); chk("t3_gnt_B", alloc_gnt_B);
    expect_v(1); chk("t3_wrB_err", wrB_rrError);
    expect_v(0); chk("t3_wrA_err", wrA_rrError);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_v(0); chk("t3_free_cnt", free_cnt);
    expect_v(1); chk("t3_full", full);

    // 4: retire two while full, allocation refused, then wrap
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_v(0); chk("t4_ret_tag_A", ret_tag_A);
    expect_v(1); chk("t4_ret_tag_B", ret_tag_B);
    expect_v(0); chk("t4_gnt_A", alloc_gnt_A);
    expect_v(0); chk("t4_ret_err", ret_err);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_v(2); chk("t4_free_cnt", free_cnt);
    expect_v(1); chk("t4_wrap_gnt_A", alloc_gnt_A);
    expect_v(0); chk("t4_wrap_tag_A", alloc_tag_A);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_v(1); chk("t4_free_after", free_cnt);

    // 5: over-retire
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_v(1); chk("t5_ret_err", ret_err);
    expect_v(0); chk("t5_ret_tag_A", ret_tag_A);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_v(1); chk("t5_empty", empty);
    expect_v(8); chk("t5_free_cnt", free_cnt);
    expect_v(0); chk("t5_ret_err_idle", ret_err);

    // 6: flush with a concurrent retire and request
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_v(3); chk("t6_free_pre", free_cnt);
    expect_v(2); chk("t6_ret_tag_A", ret_tag_A);
    expect_v(0); chk("t6_gnt_A", alloc_gnt_A);
    expect_v(0); chk("t6_wrA_err", wrA_rrError);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_v(1); chk("t6_empty", empty);
    expect_v(3); chk("t6_ret_tag_A_post", ret_tag_A);
    expect_v(1); chk("t6_gnt_A_post", alloc_gnt_A);
    expect_v(3); chk("t6_tag_A_post", alloc_tag_A);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_v(1); chk("t6_gnt_B_alone", alloc_gnt_B);
    expect_v(4); chk("t6_tag_B_alone", alloc_tag_B);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_v(6); chk("t6_free_end", free_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
